// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// states, opcode/func fields, ALU operations and datapath select codes.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    // Exactly one flag is set for any op/func pair.
    typedef struct packed {
        logic r_alu;
        logic r_shift;
        logic jr;
        logic addi;
        logic andi;
        logic ori;
        logic xori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Instruction decoder: op/func to one-hot instruction class plus the
// ALU operation used by R-type arithmetic and shift instructions.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_t    cls,
    output logic [3:0] raluc
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cls   = '0;
        raluc = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD: begin cls.r_alu   = 1'b1; raluc = ALU_ADD; end
                    FN_SUB: begin cls.r_alu   = 1'b1; raluc = ALU_SUB; end
                    FN_AND: begin cls.r_alu   = 1'b1; raluc = ALU_AND; end
                    FN_OR:  begin cls.r_alu   = 1'b1; raluc = ALU_OR;  end
                    FN_XOR: begin cls.r_alu   = 1'b1; raluc = ALU_XOR; end
                    FN_SLL: begin cls.r_shift = 1'b1; raluc = ALU_SLL; end
                    FN_SRL: begin cls.r_shift = 1'b1; raluc = ALU_SRL; end
                    FN_SRA: begin cls.r_shift = 1'b1; raluc = ALU_SRA; end
                    FN_JR:  cls.jr = 1'b1;
                    default: cls.illegal = 1'b1;
                endcase
            end
            OP_ADDI: cls.addi    = 1'b1;
            OP_ANDI: cls.andi    = 1'b1;
            OP_ORI:  cls.ori     = 1'b1;
            OP_XORI: cls.xori    = 1'b1;
            OP_LUI:  cls.lui     = 1'b1;
            OP_LW:   cls.lw      = 1'b1;
            OP_SW:   cls.sw      = 1'b1;
            OP_BEQ:  cls.beq     = 1'b1;
            OP_BNE:  cls.bne     = 1'b1;
            OP_J:    cls.j       = 1'b1;
            OP_JAL:  cls.jal     = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: registered state, combinational datapath controls.
// Write enables are suppressed while reset is held so an abandoned instruction has no side effects.
module mc_control_unit
    import mc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic [3:0] aluc,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic [1:0] pcsource,
    output logic       illegal,
    output logic [2:0] state
);

    state_t     cur;
    iclass_t    cls;
    logic [3:0] raluc;
    logic       pc_we, ir_we, mem_we, reg_we;

    mc_decode u_decode (
        .op    (op),
        .func  (func),
        .cls   (cls),
        .raluc (raluc)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur <= S_IF;
        end else begin
            case (cur)
                S_IF:  cur <= S_ID;
                S_ID:  cur <= (cls.j | cls.jal | cls.jr | cls.illegal) ? S_IF : S_EXE;
                S_EXE: begin
                    if (cls.lw | cls.sw)        cur <= S_MEM;
                    else if (cls.beq | cls.bne) cur <= S_IF;
                    else                        cur <= S_WB;
                end
                S_MEM: cur <= cls.lw ? S_WB : S_IF;
                default: cur <= S_IF;
            endcase
        end
    end

    always_comb begin
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        aluc     = ALU_ADD;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_RT;
        sext     = 1'b0;
        pcsource = PC_ALU;
        illegal  = 1'b0;
        case (cur)
            S_IF: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                alusrcb = SRCB_FOUR;
            end
            S_ID: begin
                // ALU computes the branch target here whatever the instruction.
                alusrcb = SRCB_BRANCH;
                if (cls.j | cls.jal) begin
                    pc_we    = 1'b1;
                    pcsource = PC_JUMP;
                end
                if (cls.jal) begin
                    reg_we = 1'b1;
                    jal    = 1'b1;
                end
                if (cls.jr) begin
                    pc_we    = 1'b1;
                    pcsource = PC_RS;
                end
                illegal = cls.illegal;
            end
            S_EXE: begin
                alusrca = 1'b1;
                if (cls.r_alu | cls.r_shift) begin
                    aluc  = raluc;
                    shift = cls.r_shift;
                end else if (cls.beq | cls.bne) begin
                    aluc = ALU_SUB;
                    if (cls.beq ? z : ~z) begin
                        pc_we    = 1'b1;
                        pcsource = PC_ALUOUT;
                    end
                end else begin
                    alusrcb = SRCB_IMM;
                    sext    = cls.addi | cls.lw | cls.sw;
                    if (cls.andi)      aluc = ALU_AND;
                    else if (cls.ori)  aluc = ALU_OR;
                    else if (cls.xori) aluc = ALU_XOR;
                    else if (cls.lui)  aluc = ALU_LUI;
                    else               aluc = ALU_ADD;
                end
            end
            S_MEM: begin
                iord   = 1'b1;
                mem_we = cls.sw;
            end
            S_WB: begin
                reg_we = 1'b1;
                regrt  = cls.addi | cls.andi | cls.ori | cls.xori | cls.lui | cls.lw;
                m2reg  = cls.lw;
            end
            default: ;
        endcase
    end

    assign wpc   = pc_we  & ~reset;
    assign wir   = ir_we  & ~reset;
    assign wmem  = mem_we & ~reset;
    assign wreg  = reg_we & ~reset;
    assign state = cur;

endmodule
